pulse_period_meter: RTL
=======================

// Module: pulse_period_meter
// PURPOSE
//  Consumer side of the tick generators: measures the period of an external, asynchronous
//  signal in microseconds by counting 1 us ticks (every_us) between consecutive rising edges.
//  Sits after the generators block; results go to display/UART logic as a valid-qualified word.
//  Flags periods that exceed the counter range as a timeout.
// PARAMETERS
//  WIDTH        20  period counter / result width in bits; full-scale = 2**WIDTH-1 us
//  SYNC_STAGES  2   flip-flops in sig_in synchronizer, legal range 2..4
// PORTS
//  clk           input   1      system clock, 100 MHz; all logic on rising edge
//  rst           input   1      synchronous, active-high reset
//  every_us      input   1      1-cycle tick, once per microsecond, synchronous to clk
//  sig_in        input   1      measured signal, asynchronous to clk
//  period_us     output  WIDTH  last completed period in us; held until next result
//  period_valid  output  1      1-cycle pulse: period_us updated this cycle
//  timeout       output  1      1-cycle pulse: no closing edge within 2**WIDTH-1 us
//  busy          output  1      high while a period is being timed (state MEASURE)
// BEHAVIOUR
//  Reset: rst sampled high -> period_us=0, period_valid=0, timeout=0, busy=0, count=0,
//   synchronizer and edge-history regs cleared, state=IDLE. Reset mid-measure drops it.
//  Edge detect: sig_in -> SYNC_STAGES flops -> one history flop; rise = sync & ~hist.
//   Rise asserts exactly SYNC_STAGES+1 clk edges after sig_in is first sampled high.
//   Rising edge during the cycle after reset release is ignored (history forced 0 -> 0).
//  FSM (2 states):
//   IDLE    : busy=0, count held at 0. rise -> MEASURE, count=0.
//   MEASURE : busy=1. every_us -> count+1.
//             rise -> period_us <= count + every_us (tick coinciding with closing edge
//             counts; tick coinciding with opening edge does not), period_valid=1 next
//             cycle-registered, count restarts at 0, stay MEASURE (closing edge opens next).
//             count reaches 2**WIDTH-1 with every_us and no rise -> timeout=1, period_us
//             unchanged, count=0, -> IDLE.
//  Outputs registered: period_valid/timeout rise one clk after the rise/overflow cycle,
//   period_us changes on same clk as period_valid.
//  Simultaneous rise + overflow tick in same cycle: rise wins; result = 2**WIDTH-1, valid.
//  Period of 0 us (two rises with no tick between) is reported as period_us=0, valid.
//  period_valid and timeout never high together; busy drops the cycle timeout rises.
//  No saturation wrap: count never exceeds 2**WIDTH-1.
// STRUCTURE
//  Shared include meter_defs.vh: state localparams ST_IDLE=1'b0, ST_MEASURE=1'b1,
//   default WIDTH, SYNC_STAGES bounds.
//  Sub-module edge_sync (SYNC_STAGES param; ports clk, rst, async_in, rise) holds the
//   synchronizer + edge detector; reusable for buttons/other async inputs.
//  Top: FSM, counter, output registers.
// TESTING  (bench drives every_us every 4 clks to shorten runs)
//  Reset: hold rst 3 cycles mid-activity -> all outputs 0, busy=0 next cycle.
//  sig_in rises at t0, again after 40 ticks -> period_valid 1 cycle, period_us=40, busy stays 1.
//  Rise coincident with every_us at close -> counted (39+1=40); at open -> not counted.
//  WIDTH=4, single rise, no second edge -> after 15 ticks timeout pulse, busy=0, period_us held.
//  Two rises 1 clk-separated glitch-free (no tick between) -> period_us=0, period_valid=1.
//  sig_in pulse shorter than 1 clk, async jitter (randomized phase) -> at most one rise per edge.

Source files
------------

// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and default geometry.
package pulse_period_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

    localparam int DEFAULT_WIDTH       = 20;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;

endpackage

// File: rtl/pulse_period_meter_edge_sync.sv
// Synchronizer plus registered rising-edge detector for an asynchronous input.
// Reusable for buttons and other slow asynchronous signals.
module edge_sync
    import pulse_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   rise_r;

    // Synchronizer chain, history flop and registered rise pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~hist_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period of an asynchronous signal in microsecond ticks between rising edges,
// reporting a valid-qualified result or a timeout when the counter range is exhausted.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             every_us,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_us,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    // One tick short of full scale: the next tick without a closing edge overflows
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             rise_s;
    meter_state_t     state_r;
    meter_state_t     state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_s;
    logic             valid_r;
    logic             valid_s;
    logic             timeout_r;
    logic             timeout_s;
    logic             busy_r;
    logic             busy_s;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .rise     (rise_s)
    );

    // Next-state, counter and result computation
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        period_s  = period_r;
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                count_s = {WIDTH{1'b0}};
                if (rise_s) begin
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A closing edge wins over an overflow tick in the same cycle
                if (rise_s) begin
                    period_s = count_r + {{(WIDTH-1){1'b0}}, every_us};
                    valid_s  = 1'b1;
                    count_s  = {WIDTH{1'b0}};
                end else if (every_us) begin
                    if (count_r == CNT_LAST) begin
                        timeout_s = 1'b1;
                        count_s   = {WIDTH{1'b0}};
                        state_s   = ST_IDLE;
                    end else begin
                        count_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = {WIDTH{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_MEASURE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= {WIDTH{1'b0}};
            period_r  <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            period_r  <= period_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
            busy_r    <= busy_s;
        end
    end

    assign period_us    = period_r;
    assign period_valid = valid_r;
    assign timeout      = timeout_r;
    assign busy         = busy_r;

endmodule
